lsu_ctrl: RTL and testbench

Load/store sequencing controller for the CPU's MEM stage. It turns the decoder's memory control bits into a handshaked data-memory transaction: byte strobes, lane-shifted store data, and sign- or zero-extended load data. It stalls the pipeline until the access completes, and sits between the decoder/ALU outputs and the data-memory port.

---
 rtl/cpu_pkg.sv | 14 +
 rtl/load_align.sv | 25 ++
 rtl/lsu_ctrl.sv | 151 +++++++++++++++
 tb/tb_lsu_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU types for the MEM-stage load/store controller and its helpers.
package cpu_pkg;

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} lsu_state_t;
   typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} lsu_size_t;

   localparam logic [3:0] WSTRB_ALL = 4'b1111;

   // Halfwords need an even address, words a 4-byte aligned one
   function automatic logic is_misaligned(input lsu_size_t size, input logic [1:0] off);
      return ((size == SZ_H) && off[0]) || ((size == SZ_W) && (off != 2'b00));
   endfunction

endpackage

// File: rtl/load_align.sv
// Lane-selects read data by byte offset and sign/zero-extends it to 32 bits.
module load_align
   import cpu_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  offset,
   input  lsu_size_t   size,
   input  logic        zero_ext,
   output logic [31:0] result
);

   logic [31:0] lane;

   assign lane = rdata >> {offset, 3'b000};

   always_comb begin
      result = lane;
      case (size)
         SZ_B:    result = {{24{~zero_ext & lane[7]}}, lane[7:0]};
         SZ_H:    result = {{16{~zero_ext & lane[15]}}, lane[15:0]};
         default: result = lane;
      endcase
   end

endmodule

// File: rtl/lsu_ctrl.sv
// MEM-stage load/store sequencer: turns decoder memory bits into one handshaked
// data-memory transaction and stalls the pipeline until it completes.
module lsu_ctrl
   import cpu_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        read_mem,
   input  logic        write_mem,
   input  logic        memout_low_byte,
   input  logic        memout_half_word,
   input  logic        padding_zero,
   input  logic        memin_low_byte,
   input  logic        memin_half_word,
   input  logic [31:0] addr,
   input  logic [31:0] store_data,
   input  logic        flush,
   output logic        mem_req,
   input  logic        mem_ready,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_wstrb,
   output logic [31:0] mem_wdata,
   input  logic        mem_resp_valid,
   input  logic [31:0] mem_rdata,
   output logic        stall,
   output logic [31:0] load_data,
   output logic        load_valid,
   output logic        misalign,
   output logic        req_conflict
);

   lsu_state_t  state, state_next;
   lsu_size_t   size_d, size_q;
   logic [1:0]  off_q;
   logic        zext_q;
   logic        abort_q;
   logic        req_any;
   logic        misaligned;
   logic        start;
   logic [3:0]  wstrb_d;
   logic [31:0] wdata_d;
   logic [31:0] aligned;

   assign req_any = read_mem | write_mem;

   // A simultaneous read and write is treated as a write
   always_comb begin
      size_d  = SZ_W;
      wstrb_d = 4'b0000;
      wdata_d = store_data;
      if (write_mem) begin
         if (memin_half_word)     size_d = SZ_H;
         else if (memin_low_byte) size_d = SZ_B;
      end else begin
         if (memout_half_word)     size_d = SZ_H;
         else if (memout_low_byte) size_d = SZ_B;
      end
      case (size_d)
         SZ_B: begin
            wdata_d = {4{store_data[7:0]}};
            wstrb_d = 4'b0001 << addr[1:0];
         end
         SZ_H: begin
            wdata_d = {2{store_data[15:0]}};
            wstrb_d = addr[1] ? 4'b1100 : 4'b0011;
         end
         default: begin
            wdata_d = store_data;
            wstrb_d = WSTRB_ALL;
         end
      endcase
      if (!write_mem) wstrb_d = 4'b0000;
   end

   assign misaligned = is_misaligned(size_d, addr[1:0]);
   assign start      = (state == IDLE) & req_any & ~flush & ~misaligned;

   always_comb begin
      state_next   = state;
      stall        = 1'b0;
      load_valid   = 1'b0;
      misalign     = 1'b0;
      req_conflict = 1'b0;
      case (state)
         IDLE: begin
            stall        = start;
            misalign     = req_any & ~flush & misaligned;
            req_conflict = read_mem & write_mem & ~flush;
            if (start) state_next = REQ;
         end
         REQ: begin
            stall = 1'b1;
            if (mem_ready)  state_next = WAIT;
            else if (flush) state_next = IDLE;
         end
         WAIT: begin
            stall = 1'b1;
            if (mem_resp_valid) state_next = DONE;
         end
         DONE: begin
            load_valid = ~mem_we & ~abort_q;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   load_align u_load_align (
      .rdata    (mem_rdata),
      .offset   (off_q),
      .size     (size_q),
      .zero_ext (zext_q),
      .result   (aligned)
   );

   // Request fields are captured once at launch so they hold steady during REQ
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= 32'h0;
         mem_wstrb <= 4'h0;
         mem_wdata <= 32'h0;
         load_data <= 32'h0;
         size_q    <= SZ_B;
         off_q     <= 2'b00;
         zext_q    <= 1'b0;
         abort_q   <= 1'b0;
      end else begin
         state   <= state_next;
         mem_req <= (state_next == REQ);
         if (start) begin
            mem_we    <= write_mem;
            mem_addr  <= {addr[31:2], 2'b00};
            mem_wstrb <= wstrb_d;
            mem_wdata <= wdata_d;
            size_q    <= size_d;
            off_q     <= addr[1:0];
            zext_q    <= padding_zero;
            abort_q   <= 1'b0;
         end
         if (((state == REQ) && flush && mem_ready) || ((state == WAIT) && flush))
            abort_q <= 1'b1;
         if ((state == WAIT) && mem_resp_valid && !mem_we)
            load_data <= aligned;
      end
   end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed vector table, hand-written corner
// sequences and randomized transactions against a byte-lane reference model.
module tb_lsu_ctrl;

   logic        clk;
   logic        rst_n;
   logic        read_mem, write_mem;
   logic        memout_low_byte, memout_half_word, padding_zero;
   logic        memin_low_byte, memin_half_word;
   logic [31:0] addr, store_data;
   logic        flush;
   logic        mem_req, mem_ready, mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_wdata;
   logic        mem_resp_valid;
   logic [31:0] mem_rdata;
   logic        stall;
   logic [31:0] load_data;
   logic        load_valid, misalign, req_conflict;

   int checks = 0;
   int errors = 0;

   typedef struct {
      bit          rd, wr, mlb, mhw, pz, slb, shw;
      logic [31:0] addr, sdata, rdata;
      int          readyDly, respDly;
   } txn_t;

   typedef struct {
      bit          mis, conflict;
      logic [31:0] addr, wdata, load;
      logic [3:0]  wstrb;
      int          stall;
   } exp_t;

   typedef struct {
      txn_t t;
      exp_t e;
   } vec_t;

   typedef struct {
      int          stallCycles, validCount, validCycle;
      logic [31:0] loadData, addr, wdata;
      logic [3:0]  wstrb;
      logic        we, sawReq, unstable, conflict, misalign, timeout;
   } obs_t;

   lsu_ctrl dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .read_mem         (read_mem),
      .write_mem        (write_mem),
      .memout_low_byte  (memout_low_byte),
      .memout_half_word (memout_half_word),
      .padding_zero     (padding_zero),
      .memin_low_byte   (memin_low_byte),
      .memin_half_word  (memin_half_word),
      .addr             (addr),
      .store_data       (store_data),
      .flush            (flush),
      .mem_req          (mem_req),
      .mem_ready        (mem_ready),
      .mem_we           (mem_we),
      .mem_addr         (mem_addr),
      .mem_wstrb        (mem_wstrb),
      .mem_wdata        (mem_wdata),
      .mem_resp_valid   (mem_resp_valid),
      .mem_rdata        (mem_rdata),
      .stall            (stall),
      .load_data        (load_data),
      .load_valid       (load_valid),
      .misalign         (misalign),
      .req_conflict     (req_conflict)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
      end
   endtask

   // Reference model: byte lanes covered by the access, lane-repeated store
   // data and arithmetically extended load value
   function automatic exp_t modelTxn(input txn_t t);
      exp_t        e;
      int          n, off;
      logic [63:0] v;
      n   = t.wr ? (t.shw ? 2 : (t.slb ? 1 : 4)) : (t.mhw ? 2 : (t.mlb ? 1 : 4));
      off = int'(t.addr[1:0]);
      e.mis      = (off % n) != 0;
      e.conflict = t.rd && t.wr;
      e.addr     = t.addr & ~32'h3;
      e.wstrb    = 4'h0;
      e.wdata    = 32'h0;
      for (int i = 0; i < 4; i++) begin
         if (t.wr && i >= off && i < off + n) e.wstrb[i] = 1'b1;
         e.wdata[8*i +: 8] = t.sdata[8*(i % n) +: 8];
      end
      v = {32'h0, t.rdata} >> (8 * off);
      if (n < 4) begin
         v = v & ((64'd1 << (8 * n)) - 64'd1);
         if (!t.pz && v[8*n-1]) v = v - (64'd1 << (8 * n));
      end
      e.load  = v[31:0];
      e.stall = e.mis ? 0 : 3 + t.readyDly + t.respDly;
      return e;
   endfunction

   // Drives one instruction in MEM and plays the memory side until the pipeline advances
   task automatic applyStimulus(input txn_t t, input bit flushWait, output obs_t o);
      int cyc, reqCount, waitCount;
      bit accepted, done;
      o = '{default: 0};
      @(posedge clk); #1;
      read_mem         = t.rd;
      write_mem        = t.wr;
      memout_low_byte  = t.mlb;
      memout_half_word = t.mhw;
      padding_zero     = t.pz;
      memin_low_byte   = t.slb;
      memin_half_word  = t.shw;
      addr             = t.addr;
      store_data       = t.sdata;
      cyc = 0; reqCount = 0; waitCount = 0; accepted = 0; done = 0;
      while (!done && cyc < 60) begin
         @(negedge clk);
         mem_ready      = 1'b0;
         mem_resp_valid = 1'b0;
         flush          = 1'b0;
         mem_rdata      = $urandom;
         if (cyc == 0) begin
            o.conflict = req_conflict;
            o.misalign = misalign;
         end
         if (stall) o.stallCycles++;
         if (load_valid) begin
            o.validCount++;
            o.validCycle = cyc;
            o.loadData   = load_data;
         end
         if (mem_req) begin
            if (!o.sawReq) begin
               o.sawReq = 1'b1;
               o.addr   = mem_addr;
               o.we     = mem_we;
               o.wstrb  = mem_wstrb;
               o.wdata  = mem_wdata;
            end else if ({o.addr, o.we, o.wstrb, o.wdata} !== {mem_addr, mem_we, mem_wstrb, mem_wdata}) begin
               o.unstable = 1'b1;
            end
            mem_ready = (reqCount == t.readyDly);
            if (mem_ready) accepted = 1;
            reqCount++;
         end else if (accepted && stall) begin
            if (flushWait && waitCount == 0) flush = 1'b1;
            mem_resp_valid = (waitCount == t.respDly);
            if (mem_resp_valid) mem_rdata = t.rdata;
            waitCount++;
         end
         if (!stall) done = 1;
         cyc++;
      end
      if (!done) o.timeout = 1'b1;
      @(posedge clk); #1;
      read_mem = 1'b0; write_mem = 1'b0; flush = 1'b0;
      mem_ready = 1'b0; mem_resp_valid = 1'b0;
   endtask

   task automatic checkTxn(input txn_t t, input exp_t e, input bit flushed, input obs_t o);
      bit expValid;
      expValid = t.rd && !t.wr && !flushed && !e.mis;
      checkOutput("timeout", o.timeout, 0);
      checkOutput("stall_cycles", o.stallCycles, e.stall);
      checkOutput("misalign", o.misalign, e.mis);
      checkOutput("req_conflict", o.conflict, e.conflict);
      checkOutput("mem_req_seen", o.sawReq, !e.mis);
      if (o.sawReq) begin
         checkOutput("mem_addr", o.addr, e.addr);
         checkOutput("mem_we", o.we, t.wr);
         checkOutput("mem_wstrb", o.wstrb, e.wstrb);
         checkOutput("req_stable", o.unstable, 0);
         if (t.wr) checkOutput("mem_wdata", o.wdata, e.wdata);
      end
      checkOutput("load_valid_count", o.validCount, expValid);
      if (expValid && o.validCount == 1) begin
         checkOutput("load_data", o.loadData, e.load);
         checkOutput("load_valid_cycle", o.validCycle, e.stall);
      end
   endtask

   vec_t vecs[12];
   obs_t o;
   txn_t t;
   exp_t e;
   bit   fl;

   initial begin
      // rd wr mlb mhw pz slb shw addr sdata rdata rdy rsp | mis cf addr wdata load wstrb stall
      vecs[0]  = '{'{1,0,1,0,0,0,0,32'h1003,32'h0,32'h80AB_CDEF,0,0}, '{0,0,32'h1000,32'h0,32'hFFFF_FF80,4'h0,3}};
      vecs[1]  = '{'{1,0,0,1,1,0,0,32'h1002,32'h0,32'hBEEF_1234,2,0}, '{0,0,32'h1000,32'h0,32'h0000_BEEF,4'h0,5}};
      vecs[2]  = '{'{0,1,0,0,0,1,0,32'h2001,32'h1234_5678,32'h0,0,0}, '{0,0,32'h2000,32'h7878_7878,32'h0,4'h2,3}};
      vecs[3]  = '{'{1,0,0,0,0,0,0,32'h3002,32'h0,32'h0,0,0}, '{1,0,32'h3000,32'h0,32'h0,4'h0,0}};
      vecs[4]  = '{'{0,1,0,0,0,0,1,32'h4002,32'hCAFE_BABE,32'h0,1,2}, '{0,0,32'h4000,32'hBABE_BABE,32'h0,4'hC,6}};
      vecs[5]  = '{'{1,0,0,1,0,0,0,32'h5000,32'h0,32'h1234_8001,0,1}, '{0,0,32'h5000,32'h0,32'hFFFF_8001,4'h0,4}};
      vecs[6]  = '{'{1,0,1,0,1,0,0,32'h6001,32'h0,32'h0000_F500,0,0}, '{0,0,32'h6000,32'h0,32'h0000_00F5,4'h0,3}};
      vecs[7]  = '{'{1,0,0,0,0,0,0,32'h7004,32'h0,32'hDEAD_BEEF,1,1}, '{0,0,32'h7004,32'h0,32'hDEAD_BEEF,4'h0,5}};
      vecs[8]  = '{'{1,1,0,0,0,0,0,32'h8000,32'h1122_3344,32'h0,0,0}, '{0,1,32'h8000,32'h1122_3344,32'h0,4'hF,3}};
      vecs[9]  = '{'{0,1,0,0,0,0,1,32'h9001,32'h5555_AAAA,32'h0,0,0}, '{1,0,32'h9000,32'h0,32'h0,4'h0,0}};
      vecs[10] = '{'{1,0,1,1,0,0,0,32'hA002,32'h0,32'h7FFF_0000,0,0}, '{0,0,32'hA000,32'h0,32'h0000_7FFF,4'h0,3}};
      vecs[11] = '{'{0,1,0,0,0,0,0,32'hB000,32'h0BAD_F00D,32'h0,3,0}, '{0,0,32'hB000,32'h0BAD_F00D,32'h0,4'hF,6}};

      rst_n = 1'b0;
      read_mem = 0; write_mem = 0; memout_low_byte = 0; memout_half_word = 0;
      padding_zero = 0; memin_low_byte = 0; memin_half_word = 0;
      addr = 0; store_data = 0; flush = 0; mem_ready = 0; mem_resp_valid = 0; mem_rdata = 0;
      repeat (2) @(negedge clk);
      checkOutput("rst_mem_req", mem_req, 0);
      checkOutput("rst_mem_we", mem_we, 0);
      checkOutput("rst_mem_addr", mem_addr, 0);
      checkOutput("rst_mem_wstrb", mem_wstrb, 0);
      checkOutput("rst_mem_wdata", mem_wdata, 0);
      checkOutput("rst_load_data", load_data, 0);
      checkOutput("rst_flags", {stall, load_valid, misalign, req_conflict}, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      for (int i = 0; i < 12; i++) begin
         applyStimulus(vecs[i].t, 1'b0, o);
         checkTxn(vecs[i].t, vecs[i].e, 1'b0, o);
      end

      // Load completes after a flush in WAIT but must not report valid data
      t = vecs[5].t;
      applyStimulus(t, 1'b1, o);
      checkTxn(t, vecs[5].e, 1'b1, o);

      // Flush in REQ before acceptance aborts; stray responses in IDLE are ignored
      @(posedge clk); #1;
      read_mem = 1; addr = 32'h1200;
      @(negedge clk);
      @(negedge clk);
      checkOutput("abort_req_up", mem_req, 1);
      flush = 1;
      @(posedge clk); #1;
      read_mem = 0; flush = 0;
      @(negedge clk);
      checkOutput("abort_idle", {mem_req, stall}, 0);
      mem_resp_valid = 1;
      @(negedge clk);
      mem_resp_valid = 0;
      checkOutput("abort_no_valid", {mem_req, stall, load_valid}, 0);

      // Reset asserted during WAIT clears everything immediately
      @(posedge clk); #1;
      read_mem = 1; addr = 32'h1300;
      @(negedge clk);
      @(negedge clk);
      checkOutput("rstw_req_up", mem_req, 1);
      mem_ready = 1;
      @(negedge clk);
      mem_ready = 0;
      checkOutput("rstw_in_wait", {mem_req, stall}, 2'b01);
      rst_n = 0; read_mem = 0;
      #1;
      checkOutput("rstw_outputs", {mem_req, mem_we, stall, load_valid, misalign, req_conflict}, 0);
      checkOutput("rstw_addr", mem_addr, 0);
      @(posedge clk); #1;
      rst_n = 1;
      @(negedge clk);
      checkOutput("rstw_idle", {mem_req, stall}, 0);

      for (int n = 0; n < 150; n++) begin
         int kind;
         kind  = $urandom_range(0, 5);
         t.rd  = (kind <= 2) || (kind == 5);
         t.wr  = (kind >= 3);
         t.mlb = 1'($urandom); t.mhw = 1'($urandom); t.pz = 1'($urandom);
         t.slb = 1'($urandom); t.shw = 1'($urandom);
         t.addr = $urandom; t.sdata = $urandom; t.rdata = $urandom;
         t.readyDly = $urandom_range(0, 3);
         t.respDly  = $urandom_range(0, 3);
         e = modelTxn(t);
         if (e.mis && $urandom_range(0, 3) != 0) begin
            t.addr[1:0] = 2'b00;
            e = modelTxn(t);
         end
         fl = ($urandom_range(0, 9) == 0);
         applyStimulus(t, fl, o);
         checkTxn(t, e, fl, o);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
